// File: rtl/load_store_unit.sv
// load_store_unit: memory-side responder for the load/store buffer.
// Runs one load or store at a time as little-endian byte transfers on the
// 8-bit RAM/IO port. Loads are sign/zero-extended and returned to the buffer
// and the CDB. Stores to IO space wait for room in the IO write buffer.
//
// Handshake: enable_from_lsb is a single-cycle request pulse. It is taken only
// when the unit is not busy (IDLE or the end-pulse cycle). end_to_lsb pulses
// once per accepted access (including an aborted load) so the buffer may issue
// again. enable_to_cdb qualifies result_to_cdb for exactly one cycle.
module load_store_unit #(
    parameter int                 ADDR_W    = 32,
    parameter int                 DATA_W    = 32,
    parameter int                 OP_W      = 6,
    parameter logic [ADDR_W-1:0]  IO_BASE   = 'h30000,
    parameter logic [OP_W-1:0]    OP_LB     = 'd1,
    parameter logic [OP_W-1:0]    OP_LH     = 'd2,
    parameter logic [OP_W-1:0]    OP_LW     = 'd3,
    parameter logic [OP_W-1:0]    OP_LBU    = 'd4,
    parameter logic [OP_W-1:0]    OP_LHU    = 'd5,
    parameter logic [OP_W-1:0]    OP_SB     = 'd6,
    parameter logic [OP_W-1:0]    OP_SH     = 'd7,
    parameter logic [OP_W-1:0]    OP_SW     = 'd8,
    parameter logic               WRITE_SIT = 1'b1
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              enable_from_lsb,
    input  logic              read_write_flag_from_lsb,
    input  logic [OP_W-1:0]   op_enum_from_lsb,
    input  logic [ADDR_W-1:0] object_address_from_lsb,
    input  logic [DATA_W-1:0] data_from_lsb,
    input  logic              roll_back_flag_from_rob,
    output logic              busy_to_lsb,
    output logic              end_to_lsb,
    output logic [DATA_W-1:0] data_to_lsb,
    output logic              enable_to_cdb,
    output logic [DATA_W-1:0] result_to_cdb,
    input  logic [7:0]        mem_din_in,
    input  logic              io_buffer_full_in,
    output logic [7:0]        mem_dout_out,
    output logic [ADDR_W-1:0] mem_a_out,
    output logic              mem_wr_out,
    output logic [2:0]        state_dbg_out
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_READ    = 3'd1,
        S_WRITE   = 3'd2,
        S_WAIT_IO = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [2:0]          idx_q, idx_d;        // byte index currently on the port
    logic [2:0]          size_q, size_d;      // access size in bytes (1, 2 or 4)
    logic                sgn_q, sgn_d;        // sign-extend the load result
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [31:0]         sdata_q, sdata_d;
    logic [31:0]         buf_q, buf_d;        // load bytes gathered so far
    logic [ADDR_W-1:0]   mem_a_q, mem_a_d;
    logic [7:0]          mem_dout_q, mem_dout_d;
    logic                wr_q, wr_d;
    logic                busy_q, busy_d;
    logic                end_q, end_d;
    logic                cdb_q, cdb_d;
    logic [DATA_W-1:0]   data_q, data_d;
    // The RAM keeps reading while rdy_in is low, so the byte that was in
    // flight when the freeze began is parked here and used on resume.
    logic                held_q;
    logic [7:0]          din_q;

    logic [7:0]          din_eff;
    logic [2:0]          req_size;
    logic                req_sgn;
    logic                req_store;
    logic                req_io;
    logic                accept;
    logic [2:0]          idx_nx;
    logic [ADDR_W-1:0]   addr_nx;
    logic [31:0]         asm_w;

    function automatic logic [7:0] pick_byte(input logic [31:0] w, input logic [2:0] k);
        case (k)
            3'd0:    return w[7:0];
            3'd1:    return w[15:8];
            3'd2:    return w[23:16];
            default: return w[31:24];
        endcase
    endfunction

    function automatic logic [DATA_W-1:0] extend(input logic [31:0] w, input logic [2:0] size,
                                                 input logic sgn);
        case (size)
            3'd1:    return {{(DATA_W-8){sgn & w[7]}}, w[7:0]};
            3'd2:    return {{(DATA_W-16){sgn & w[15]}}, w[15:0]};
            default: return DATA_W'(w);
        endcase
    endfunction

    // Decode the incoming request: size, signedness, direction, IO target.
    always_comb begin
        req_size = 3'd4;
        req_sgn  = 1'b0;
        case (op_enum_from_lsb)
            OP_LB:        begin req_size = 3'd1; req_sgn = 1'b1; end
            OP_LBU, OP_SB: req_size = 3'd1;
            OP_LH:        begin req_size = 3'd2; req_sgn = 1'b1; end
            OP_LHU, OP_SH: req_size = 3'd2;
            OP_LW, OP_SW: req_size = 3'd4;
            default:      req_size = 3'd4;
        endcase
        req_store = (read_write_flag_from_lsb == WRITE_SIT);
        req_io    = (object_address_from_lsb >= IO_BASE);
        // A flush drops a new load but a store is already committed.
        accept    = enable_from_lsb & (req_store | ~roll_back_flag_from_rob);
    end

    // Helpers for stepping through the bytes of the current access.
    always_comb begin
        din_eff = held_q ? din_q : mem_din_in;
        idx_nx  = idx_q + 3'd1;
        addr_nx = base_q + ADDR_W'(idx_nx);
        asm_w   = buf_q;
        case (idx_q)
            3'd1:    asm_w[7:0]   = din_eff;
            3'd2:    asm_w[15:8]  = din_eff;
            3'd3:    asm_w[23:16] = din_eff;
            3'd4:    asm_w[31:24] = din_eff;
            default: asm_w        = buf_q;
        endcase
    end

    // Next-state and registered-output logic of the access FSM.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        size_d     = size_q;
        sgn_d      = sgn_q;
        base_d     = base_q;
        sdata_d    = sdata_q;
        buf_d      = buf_q;
        mem_a_d    = mem_a_q;
        mem_dout_d = mem_dout_q;
        wr_d       = wr_q;
        end_d      = 1'b0;
        cdb_d      = 1'b0;
        data_d     = data_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                state_d    = S_IDLE;
                mem_a_d    = '0;
                mem_dout_d = '0;
                wr_d       = 1'b0;
                if (accept) begin
                    idx_d   = 3'd0;
                    size_d  = req_size;
                    sgn_d   = req_sgn;
                    base_d  = object_address_from_lsb;
                    sdata_d = data_from_lsb[31:0];
                    mem_a_d = object_address_from_lsb;
                    if (!req_store) begin
                        state_d = S_READ;
                        buf_d   = '0;
                    end else begin
                        mem_dout_d = data_from_lsb[7:0];
                        if (req_io && io_buffer_full_in) begin
                            state_d = S_WAIT_IO;
                        end else begin
                            state_d = S_WRITE;
                            wr_d    = 1'b1;
                        end
                    end
                end
            end
            S_READ: begin
                if (roll_back_flag_from_rob) begin
                    // Abort the load but still release the buffer's interlock.
                    state_d = S_IDLE;
                    end_d   = 1'b1;
                    mem_a_d = '0;
                end else begin
                    // Byte idx-1 arrives this cycle (nothing yet when idx is 0).
                    buf_d = asm_w;
                    if (idx_q == size_q) begin
                        state_d = S_DONE;
                        end_d   = 1'b1;
                        cdb_d   = 1'b1;
                        data_d  = extend(asm_w, size_q, sgn_q);
                        mem_a_d = '0;
                    end else begin
                        idx_d = idx_nx;
                        if (idx_nx < size_q) begin
                            mem_a_d = addr_nx;
                        end
                    end
                end
            end
            S_WRITE: begin
                // The byte on the port is written this cycle.
                if (idx_q == size_q - 3'd1) begin
                    state_d    = S_DONE;
                    end_d      = 1'b1;
                    wr_d       = 1'b0;
                    mem_a_d    = '0;
                    mem_dout_d = '0;
                end else begin
                    idx_d      = idx_nx;
                    mem_a_d    = addr_nx;
                    mem_dout_d = pick_byte(sdata_q, idx_nx);
                    if ((addr_nx >= IO_BASE) && io_buffer_full_in) begin
                        state_d = S_WAIT_IO;
                        wr_d    = 1'b0;
                    end else begin
                        state_d = S_WRITE;
                        wr_d    = 1'b1;
                    end
                end
            end
            S_WAIT_IO: begin
                // Address and data stay put until the IO buffer has room.
                if (!io_buffer_full_in) begin
                    state_d = S_WRITE;
                    wr_d    = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                mem_a_d = '0;
                wr_d    = 1'b0;
            end
        endcase
        busy_d = (state_d == S_READ) || (state_d == S_WRITE) || (state_d == S_WAIT_IO);
    end

    // State register: reset wins, rdy_in low freezes everything.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            size_q     <= '0;
            sgn_q      <= 1'b0;
            base_q     <= '0;
            sdata_q    <= '0;
            buf_q      <= '0;
            mem_a_q    <= '0;
            mem_dout_q <= '0;
            wr_q       <= 1'b0;
            busy_q     <= 1'b0;
            end_q      <= 1'b0;
            cdb_q      <= 1'b0;
            data_q     <= '0;
            held_q     <= 1'b0;
            din_q      <= '0;
        end else if (rdy_in) begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            size_q     <= size_d;
            sgn_q      <= sgn_d;
            base_q     <= base_d;
            sdata_q    <= sdata_d;
            buf_q      <= buf_d;
            mem_a_q    <= mem_a_d;
            mem_dout_q <= mem_dout_d;
            wr_q       <= wr_d;
            busy_q     <= busy_d;
            end_q      <= end_d;
            cdb_q      <= cdb_d;
            data_q     <= data_d;
            held_q     <= 1'b0;
        end else if (!held_q) begin
            held_q <= 1'b1;
            din_q  <= mem_din_in;
        end
    end

    assign busy_to_lsb   = busy_q;
    assign end_to_lsb    = end_q;
    assign data_to_lsb   = data_q;
    assign result_to_cdb = data_q;
    assign enable_to_cdb = cdb_q & ~roll_back_flag_from_rob;
    assign mem_a_out     = mem_a_q;
    assign mem_dout_out  = mem_dout_q;
    assign mem_wr_out    = wr_q & rdy_in;
    assign state_dbg_out = state_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a table of accesses with hand-computed
// results plus hand-written cycle-by-cycle sequences for the corner cases.
module tb_load_store_unit;

    localparam logic [5:0] OP_LB  = 6'd1;
    localparam logic [5:0] OP_LH  = 6'd2;
    localparam logic [5:0] OP_LW  = 6'd3;
    localparam logic [5:0] OP_LBU = 6'd4;
    localparam logic [5:0] OP_LHU = 6'd5;
    localparam logic [5:0] OP_SB  = 6'd6;
    localparam logic [5:0] OP_SH  = 6'd7;
    localparam logic [5:0] OP_SW  = 6'd8;
    localparam int NC = 14;

    // ---------------- clock / reset / DUT ----------------
    logic        clk = 1'b0;
    logic        rst, rdy, en, rw, roll, io_full;
    logic [5:0]  op;
    logic [31:0] addr, data;
    logic        busy, endp, cdb, mwr;
    logic [31:0] d_lsb, res, ma;
    logic [7:0]  din, dout;
    logic [2:0]  st_dbg;

    always #5 clk = ~clk;

    load_store_unit dut (
        .clk_in                   (clk),
        .rst_in                   (rst),
        .rdy_in                   (rdy),
        .enable_from_lsb          (en),
        .read_write_flag_from_lsb (rw),
        .op_enum_from_lsb         (op),
        .object_address_from_lsb  (addr),
        .data_from_lsb            (data),
        .roll_back_flag_from_rob  (roll),
        .busy_to_lsb              (busy),
        .end_to_lsb               (endp),
        .data_to_lsb              (d_lsb),
        .enable_to_cdb            (cdb),
        .result_to_cdb            (res),
        .mem_din_in               (din),
        .io_buffer_full_in        (io_full),
        .mem_dout_out             (dout),
        .mem_a_out                (ma),
        .mem_wr_out               (mwr),
        .state_dbg_out            (st_dbg)
    );

    // RAM model: one-cycle read latency, write when mem_wr_out is high.
    logic [7:0] ram [0:16383];

    function automatic int ridx(input logic [31:0] a);
        return int'({a[17:16], a[11:0]});
    endfunction

    always @(posedge clk) begin
        din <= ram[ridx(ma)];
        if (mwr) ram[ridx(ma)] = dout;
    end

    function automatic logic [31:0] ram_word(input logic [31:0] a, input int n);
        logic [31:0] w;
        w = '0;
        for (int k = 0; k < n; k++) w[8*k +: 8] = ram[ridx(a + 32'(k))];
        return w;
    endfunction

    function automatic int nbytes(input logic [5:0] o);
        if (o == OP_LB || o == OP_LBU || o == OP_SB) return 1;
        if (o == OP_LH || o == OP_LHU || o == OP_SH) return 2;
        return 4;
    endfunction

    // ---------------- scoreboard ----------------
    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // ---------------- vectors ----------------
    typedef struct {
        string       name;
        logic        w;
        logic [5:0]  o;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] init;     // RAM bytes at a..a+3, little-endian
        int          roll_c;   // cycle with rollback high (-1 none)
        int          rdy_s;    // first cycle with rdy low
        int          rdy_l;    // number of rdy-low cycles
        int          io_u;     // io_full high in cycles 0..io_u-1
        int          rst_c;    // cycle with reset high (-1 none)
        int          e_end;    // first end_to_lsb cycle (-1 none)
        logic        e_cdb;
        logic [31:0] e_res;
        int          e_nend;
        int          e_nwr;
    } vec_t;

    function automatic vec_t mk(input string nm, input logic w, input logic [5:0] o,
                                input logic [31:0] a, input logic [31:0] d, input logic [31:0] init,
                                input int roll_c, input int rdy_s, input int rdy_l, input int io_u,
                                input int rst_c, input int e_end, input logic e_cdb,
                                input logic [31:0] e_res, input int e_nend, input int e_nwr);
        vec_t v;
        v.name = nm; v.w = w; v.o = o; v.a = a; v.d = d; v.init = init;
        v.roll_c = roll_c; v.rdy_s = rdy_s; v.rdy_l = rdy_l; v.io_u = io_u; v.rst_c = rst_c;
        v.e_end = e_end; v.e_cdb = e_cdb; v.e_res = e_res; v.e_nend = e_nend; v.e_nwr = e_nwr;
        return v;
    endfunction

    vec_t vecs[$];

    // Second request issued during a run (-1 = none).
    int          xen_c = -1;
    logic [5:0]  xen_op;
    logic [31:0] xen_addr, xen_data;

    logic        tr_end [NC];
    logic        tr_cdb [NC];
    logic        tr_busy[NC];
    logic        tr_wr  [NC];
    logic [31:0] tr_a   [NC];
    logic [7:0]  tr_dout[NC];
    logic [31:0] tr_res [NC];
    logic [31:0] tr_dl  [NC];

    // ---------------- driver ----------------
    // Entered and left just after a rising edge. Cycle 0 carries the request.
    task automatic run_vec(input vec_t v);
        for (int k = 0; k < 4; k++) ram[ridx(v.a + 32'(k))] = v.init[8*k +: 8];
        for (int c = 0; c < NC; c++) begin
            rst     = (c == v.rst_c);
            roll    = (c == v.roll_c);
            rdy     = !(c >= v.rdy_s && c < v.rdy_s + v.rdy_l);
            io_full = (c < v.io_u);
            en      = (c == 0) || (c == xen_c);
            if (c == xen_c) begin
                rw = 1'b1; op = xen_op; addr = xen_addr; data = xen_data;
            end else begin
                rw = v.w; op = v.o; addr = v.a; data = v.d;
            end
            #4;
            tr_end[c] = endp; tr_cdb[c] = cdb; tr_busy[c] = busy; tr_wr[c] = mwr;
            tr_a[c] = ma; tr_dout[c] = dout; tr_res[c] = res; tr_dl[c] = d_lsb;
            @(posedge clk); #1;
        end
        en = 0; roll = 0; rdy = 1; io_full = 0; rst = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
    endtask

    task automatic check_vec(input vec_t v);
        int first, nend, ncdb, nwr;
        first = -1; nend = 0; ncdb = 0; nwr = 0;
        for (int c = 0; c < NC; c++) begin
            if (tr_end[c] && first < 0) first = c;
            nend += int'(tr_end[c]);
            ncdb += int'(tr_cdb[c]);
            nwr  += int'(tr_wr[c]);
        end
        chk({v.name, ".end_cycle"}, 32'(first), 32'(v.e_end));
        chk({v.name, ".n_end"}, 32'(nend), 32'(v.e_nend));
        chk({v.name, ".n_cdb"}, 32'(ncdb), v.e_cdb ? 32'd1 : 32'd0);
        chk({v.name, ".n_wr"}, 32'(nwr), 32'(v.e_nwr));
        if (first >= 0) begin
            chk({v.name, ".busy_at_end"}, 32'(tr_busy[first]), 32'd0);
            if (v.e_cdb) begin
                chk({v.name, ".result"}, tr_res[first], v.e_res);
                chk({v.name, ".data_to_lsb"}, tr_dl[first], v.e_res);
            end
        end
        if (v.w && v.rst_c < 0) begin
            chk({v.name, ".ram"}, ram_word(v.a, nbytes(v.o)),
                ram_word_expect(v.d, nbytes(v.o)));
        end
    endtask

    function automatic logic [31:0] ram_word_expect(input logic [31:0] d, input int n);
        if (n == 1) return {24'h0, d[7:0]};
        if (n == 2) return {16'h0, d[15:0]};
        return d;
    endfunction

    // ---------------- test ----------------
    initial begin
        vec_t v;
        for (int i = 0; i < 16384; i++) ram[i] = 8'h00;
        rst = 1; rdy = 1; en = 0; rw = 0; op = '0; addr = '0; data = '0; roll = 0; io_full = 0;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        #4;
        chk("reset.busy", 32'(busy), 0);
        chk("reset.end", 32'(endp), 0);
        chk("reset.cdb", 32'(cdb), 0);
        chk("reset.wr", 32'(mwr), 0);
        chk("reset.addr", ma, 0);
        chk("reset.dout", 32'(dout), 0);
        chk("reset.result", res, 0);
        chk("reset.data_to_lsb", d_lsb, 0);
        @(posedge clk); #1;

        //             name           w     op      addr        data          init          roll rs rl io rst end cdb res           ne nw
        vecs.push_back(mk("lw",       1'b0, OP_LW,  32'h100,   32'h0,        32'h12345678, -1, -1, 0, 0, -1, 6, 1, 32'h12345678, 1, 0));
        vecs.push_back(mk("lb_neg",   1'b0, OP_LB,  32'h200,   32'h0,        32'h00000080, -1, -1, 0, 0, -1, 3, 1, 32'hFFFFFF80, 1, 0));
        vecs.push_back(mk("lbu",      1'b0, OP_LBU, 32'h200,   32'h0,        32'h00000080, -1, -1, 0, 0, -1, 3, 1, 32'h00000080, 1, 0));
        vecs.push_back(mk("lh_neg",   1'b0, OP_LH,  32'h210,   32'h0,        32'h00008000, -1, -1, 0, 0, -1, 4, 1, 32'hFFFF8000, 1, 0));
        vecs.push_back(mk("lhu",      1'b0, OP_LHU, 32'h210,   32'h0,        32'h00008000, -1, -1, 0, 0, -1, 4, 1, 32'h00008000, 1, 0));
        vecs.push_back(mk("lb_pos",   1'b0, OP_LB,  32'h220,   32'h0,        32'h0000007F, -1, -1, 0, 0, -1, 3, 1, 32'h0000007F, 1, 0));
        vecs.push_back(mk("lw_roll3", 1'b0, OP_LW,  32'h100,   32'h0,        32'h12345678,  3, -1, 0, 0, -1, 4, 0, 32'h0,        1, 0));
        vecs.push_back(mk("lw_rollend",1'b0,OP_LW,  32'h100,   32'h0,        32'h12345678,  6, -1, 0, 0, -1, 6, 0, 32'h0,        1, 0));
        vecs.push_back(mk("lw_rollissue",1'b0,OP_LW,32'h100,   32'h0,        32'h12345678,  0, -1, 0, 0, -1,-1, 0, 32'h0,        0, 0));
        vecs.push_back(mk("lw_rdy",   1'b0, OP_LW,  32'h100,   32'h0,        32'h12345678, -1,  2, 2, 0, -1, 8, 1, 32'h12345678, 1, 0));
        vecs.push_back(mk("sb",       1'b1, OP_SB,  32'h310,   32'h11223344, 32'h0,        -1, -1, 0, 0, -1, 2, 0, 32'h0,        1, 1));
        vecs.push_back(mk("sh",       1'b1, OP_SH,  32'h300,   32'hABCD1234, 32'h0,        -1, -1, 0, 0, -1, 3, 0, 32'h0,        1, 2));
        vecs.push_back(mk("sw",       1'b1, OP_SW,  32'h320,   32'hCAFEF00D, 32'h0,        -1, -1, 0, 0, -1, 5, 0, 32'h0,        1, 4));
        vecs.push_back(mk("sb_io",    1'b1, OP_SB,  32'h30000, 32'h00000041, 32'h0,        -1, -1, 0, 3, -1, 5, 0, 32'h0,        1, 1));
        vecs.push_back(mk("sw_rdy",   1'b1, OP_SW,  32'h330,   32'h01020304, 32'h0,        -1,  2, 1, 0, -1, 6, 0, 32'h0,        1, 4));
        vecs.push_back(mk("sw_roll",  1'b1, OP_SW,  32'h350,   32'h9ABCDEF0, 32'h0,         2, -1, 0, 0, -1, 5, 0, 32'h0,        1, 4));
        vecs.push_back(mk("sb_rollissue",1'b1,OP_SB,32'h360,   32'h0000005A, 32'h0,         0, -1, 0, 0, -1, 2, 0, 32'h0,        1, 1));
        vecs.push_back(mk("sw_rst",   1'b1, OP_SW,  32'h340,   32'h55667788, 32'h0,        -1, -1, 0, 0,  2,-1, 0, 32'h0,        0, 2));

        foreach (vecs[i]) begin
            run_vec(vecs[i]);
            check_vec(vecs[i]);
        end

        // Reset mid-store: only the two bytes written before the reset edge land.
        chk("sw_rst.ram", ram_word(32'h340, 4), 32'h00007788);

        // LW address sequence.
        v = mk("lw_seq", 1'b0, OP_LW, 32'h100, 32'h0, 32'h12345678, -1, -1, 0, 0, -1, 6, 1, 32'h12345678, 1, 0);
        run_vec(v);
        for (int c = 1; c <= 4; c++) chk($sformatf("lw_seq.addr%0d", c), tr_a[c], 32'h100 + 32'(c - 1));
        chk("lw_seq.busy5", 32'(tr_busy[5]), 1);
        chk("lw_seq.addr_after", tr_a[6], 0);

        // SH byte-by-byte writes.
        v = mk("sh_seq", 1'b1, OP_SH, 32'h300, 32'hABCD1234, 32'h0, -1, -1, 0, 0, -1, 3, 0, 32'h0, 1, 2);
        run_vec(v);
        chk("sh_seq.wr1", 32'(tr_wr[1]), 1);
        chk("sh_seq.a1", tr_a[1], 32'h300);
        chk("sh_seq.d1", 32'(tr_dout[1]), 32'h34);
        chk("sh_seq.wr2", 32'(tr_wr[2]), 1);
        chk("sh_seq.a2", tr_a[2], 32'h301);
        chk("sh_seq.d2", 32'(tr_dout[2]), 32'h12);
        chk("sh_seq.wr3", 32'(tr_wr[3]), 0);
        chk("sh_seq.end3", 32'(tr_end[3]), 1);

        // IO store held off while the IO buffer is full (sampled full at the
        // edges into cycles 1..3).
        v = mk("sb_io_seq", 1'b1, OP_SB, 32'h30000, 32'h00000041, 32'h0, -1, -1, 0, 3, -1, 5, 0, 32'h0, 1, 1);
        run_vec(v);
        chk("sb_io_seq.wr1to3", 32'({tr_wr[1], tr_wr[2], tr_wr[3]}), 0);
        chk("sb_io_seq.a_held", tr_a[2], 32'h30000);
        chk("sb_io_seq.wr4", 32'(tr_wr[4]), 1);
        chk("sb_io_seq.a4", tr_a[4], 32'h30000);
        chk("sb_io_seq.d4", 32'(tr_dout[4]), 32'h41);
        chk("sb_io_seq.end5", 32'(tr_end[5]), 1);

        // Rollback aborts an LW; an SW issued in the abort cycle runs normally.
        xen_c = 4; xen_op = OP_SW; xen_addr = 32'h400; xen_data = 32'hDEADBEEF;
        v = mk("roll_sw", 1'b0, OP_LW, 32'h100, 32'h0, 32'h12345678, 3, -1, 0, 0, -1, 4, 0, 32'h0, 2, 4);
        run_vec(v);
        chk("roll_sw.end4", 32'(tr_end[4]), 1);
        chk("roll_sw.cdb4", 32'(tr_cdb[4]), 0);
        chk("roll_sw.busy4", 32'(tr_busy[4]), 0);
        for (int c = 5; c <= 8; c++) begin
            chk($sformatf("roll_sw.wr%0d", c), 32'(tr_wr[c]), 1);
            chk($sformatf("roll_sw.a%0d", c), tr_a[c], 32'h400 + 32'(c - 5));
        end
        chk("roll_sw.d5", 32'(tr_dout[5]), 32'hEF);
        chk("roll_sw.d8", 32'(tr_dout[8]), 32'hDE);
        chk("roll_sw.end9", 32'(tr_end[9]), 1);
        chk("roll_sw.ram", ram_word(32'h400, 4), 32'hDEADBEEF);

        // rdy low for two cycles plus a stray enable while busy.
        xen_c = 5; xen_op = OP_SW; xen_addr = 32'h500; xen_data = 32'h77777777;
        v = mk("rdy_en", 1'b0, OP_LW, 32'h100, 32'h0, 32'h12345678, -1, 2, 2, 0, -1, 8, 1, 32'h12345678, 1, 0);
        run_vec(v);
        check_vec(v);
        chk("rdy_en.stray_ram", ram_word(32'h500, 4), 32'h0);
        xen_c = -1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
